// File: rtl/pia_handshake_source.sv
// Queues producer bytes and hands them to the PIA port A input with a CA1 strobe / CA2 ack handshake.
// Push-to-pa_data is two clocks; in_ready drops when the queue is full, and a byte leaves only on ack or timeout.
module pia_handshake_source #(
   parameter int FIFO_DEPTH   = 4,
   parameter int SETUP_CYC    = 2,
   parameter int STROBE_CYC   = 4,
   parameter int TIMEOUT_CYC  = 65535,
   parameter bit CA1_ACT_HIGH = 1'b0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [7:0]                    pa_data,
   output logic                          ca1_out,
   input  logic                          ca2_in,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          timeout_err,
   input  logic                          clr_err
);

   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int MAX_A  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int MAX_C  = (TIMEOUT_CYC > MAX_A) ? TIMEOUT_CYC : MAX_A;
   localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;
   localparam int TMO_M1 = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

   localparam logic [CW-1:0] SETUP_LD   = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] STROBE_LD  = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0] TIMEOUT_LD = CW'(TMO_M1);
   localparam logic [PW:0]   FULL       = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]   ONE        = (PW+1)'(1);
   localparam bit            TMO_EN     = (TIMEOUT_CYC != 0);
   localparam logic          CA1_ON     = CA1_ACT_HIGH;
   localparam logic          CA1_OFF    = !CA1_ACT_HIGH;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, WAIT_ACK} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [PW:0]     count;
   logic            head_ok;
   logic            ca2_s1, ca2_s2, ca2_s3;
   logic            ack_pend;
   logic            ack_evt;
   logic            ack_any;
   logic            tmo_hit;
   logic            push;
   logic            pop;
   logic            tmo_pop;

   assign in_ready   = !reset && (count != FULL);
   assign push       = in_valid && in_ready;
   assign ack_evt    = ca2_s3 && !ca2_s2;
   assign ack_any    = ack_evt || ack_pend;
   assign tmo_hit    = TMO_EN && (cnt == '0);
   assign pop        = (state == WAIT_ACK) && (ack_any || tmo_hit);
   assign tmo_pop    = (state == WAIT_ACK) && !ack_any && tmo_hit;
   assign busy       = (state != IDLE);
   assign fifo_count = count;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // head_ok lags the queue by a clock, so a freshly written byte is launched one cycle after it lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         head_ok <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         head_ok <= (count != '0) && !(pop && (count == ONE));
      end
   end

   // CA2 idles high, so the synchroniser resets high to avoid a false ack after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ca2_s1 <= 1'b1;
         ca2_s2 <= 1'b1;
         ca2_s3 <= 1'b1;
      end else begin
         ca2_s1 <= ca2_in;
         ca2_s2 <= ca2_s1;
         ca2_s3 <= ca2_s2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         pa_data     <= 8'hFF;
         ca1_out     <= CA1_OFF;
         ack_pend    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (tmo_pop)      timeout_err <= 1'b1;
         else if (clr_err) timeout_err <= 1'b0;

         case (state)
            IDLE: begin
               ack_pend <= 1'b0;
               if (enable && head_ok) begin
                  pa_data <= mem[rd_ptr];
                  cnt     <= SETUP_LD;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               if (ack_evt) ack_pend <= 1'b1;
               if (cnt == '0) begin
                  ca1_out <= CA1_ON;
                  cnt     <= STROBE_LD;
                  state   <= STROBE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            STROBE: begin
               if (ack_evt) ack_pend <= 1'b1;
               if (cnt == '0) begin
                  ca1_out <= CA1_OFF;
                  cnt     <= TIMEOUT_LD;
                  state   <= WAIT_ACK;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WAIT_ACK: begin
               if (ack_any) begin
                  ack_pend <= 1'b0;
                  state    <= IDLE;
               end else if (tmo_hit) begin
                  state <= IDLE;
               end else if (TMO_EN) begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pia_handshake_source.sv
// Bench for pia_handshake_source: PIA ack model, byte/outcome scoreboard and directed plus random traffic.
module tb_pia_handshake_source;

   localparam int DEPTH  = 4;
   localparam int SETUP  = 2;
   localparam int STROBE = 4;
   localparam int TMO    = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] pa_data;
   logic       ca1_out;
   logic       ca2_in = 1'b1;
   logic       busy;
   logic [2:0] fifo_count;
   logic       timeout_err;
   logic       clr_err = 1'b0;

   pia_handshake_source #(
      .FIFO_DEPTH(DEPTH), .SETUP_CYC(SETUP), .STROBE_CYC(STROBE),
      .TIMEOUT_CYC(TMO), .CA1_ACT_HIGH(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .pa_data(pa_data), .ca1_out(ca1_out), .ca2_in(ca2_in),
      .busy(busy), .fifo_count(fifo_count),
      .timeout_err(timeout_err), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int comp;
      bit tmo;
   } out_t;

   logic [7:0] exp_q[$];
   out_t       out_q[$];
   int passed = 0;
   int total = 0;
   int pushes = 0;
   int completions = 0;
   int strobes = 0;
   int ack_mode = 1;   // 0 never ack, 1 always ack, 2 mostly ack
   int ack_d = -1;     // fixed ack delay after CA1 goes active, or random when negative

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
   endtask

   task automatic push(input logic [7:0] d, output int n);
      int w;
      w = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      n = cyc + 1;
      if (!in_ready) begin
         check("push_ready_wait", in_ready, 1'b1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         exp_q.push_back(d);
         pushes++;
      end
   endtask

   task automatic at_edge(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(busy == 1'b0 && fifo_count == 3'd0) && n < budget);
      check("drain_busy", busy, 1'b0);
   endtask

   task automatic wait_ca1_active();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ca1_out !== 1'b0 && n < 100);
      check("ca1_seen", ca1_out, 1'b0);
   endtask

   // PIA model: decides ack or silence per strobe and records when the transfer must finish.
   initial begin : pia
      bit prev;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!reset && ca1_out == 1'b0 && prev) begin
            int a, d;
            bit ack;
            out_t o;
            a   = cyc;
            ack = (ack_mode == 1) || (ack_mode == 2 && $urandom_range(0, 7) != 0);
            d   = (ack_d >= 0) ? ack_d : int'($urandom_range(0, 15));
            if (ack) begin
               o.tmo  = 1'b0;
               o.comp = (a + d + 3 > a + STROBE + 1) ? a + d + 3 : a + STROBE + 1;
            end else begin
               o.tmo  = 1'b1;
               o.comp = a + STROBE + TMO;
            end
            out_q.push_back(o);
            if (ack) begin
               repeat (d) @(negedge clk);
               ca2_in = 1'b0;
               repeat (2) @(negedge clk);
               ca2_in = 1'b1;
            end
         end
         prev = ca1_out;
      end
   end

   initial begin : mon
      bit pb, pc, pe, stable;
      int load_c, act_c;
      logic [7:0] ld;
      out_t o;
      pb = 1'b0; pc = 1'b1; pe = 1'b0; stable = 1'b1;
      load_c = 0; act_c = 0; ld = 8'h00;
      forever begin
         @(negedge clk);
         if (reset) begin
            pb = 1'b0; pc = 1'b1; pe = 1'b0;
         end else begin
            if (busy && !pb) begin
               load_c = cyc; ld = pa_data; stable = 1'b1;
               if (exp_q.size() == 0) check("load_unexpected", 1, 0);
               else check("sb_byte", pa_data, exp_q.pop_front());
            end
            if (busy && pa_data !== ld) stable = 1'b0;
            if (!ca1_out && pc) begin
               strobes++;
               check("setup_cycles", cyc - load_c, SETUP);
               act_c = cyc;
            end
            if (ca1_out && !pc) check("strobe_cycles", cyc - act_c, STROBE);
            if (!busy && pb) begin
               completions++;
               check("pa_hold", {stable, pa_data}, {1'b1, ld});
               if (out_q.size() == 0) check("comp_unexpected", 1, 0);
               else begin
                  o = out_q.pop_front();
                  check("comp_cycle", cyc, o.comp);
                  if (o.tmo) check("tmo_set", timeout_err, 1'b1);
                  else if (!pe) check("no_tmo", timeout_err, 1'b0);
               end
            end
            check("fifo_count", fifo_count, pushes - completions);
            pb = busy; pc = ca1_out; pe = timeout_err;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $display("%0d/%0d checks passed", passed, total + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n, s, g;
      reset = 1'b1; in_valid = 1'b1; in_data = 8'h33;
      repeat (3) @(negedge clk);
      check("rst_pa", pa_data, 8'hFF);
      check("rst_ca1", ca1_out, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_count", fifo_count, 0);
      check("rst_err", timeout_err, 1'b0);
      check("rst_ready", in_ready, 1'b0);
      in_valid = 1'b0; reset = 1'b0; enable = 1'b1;
      @(negedge clk);
      check("rst_push_ignored", fifo_count, 0);
      check("ready_after_rst", in_ready, 1'b1);

      // single byte, ack 5 cycles after CA1
      ack_mode = 1; ack_d = 5;
      push(8'hA5, n);
      at_edge(n + 1); check("t1_not_loaded", busy, 1'b0);
      at_edge(n + 2); check("t1_pa_load", {busy, pa_data}, {1'b1, 8'hA5});
      at_edge(n + 3); check("t1_ca1_pre", ca1_out, 1'b1);
      at_edge(n + 4); check("t1_ca1_on", ca1_out, 1'b0);
      at_edge(n + 7); check("t1_ca1_hold", ca1_out, 1'b0);
      at_edge(n + 8); check("t1_ca1_off", ca1_out, 1'b1);
      wait_idle(200);
      check("t1_count", fifo_count, 0);

      // fill the queue, fifth push waits for the first pop
      ack_d = -1;
      for (int i = 1; i <= 4; i++) push(8'(i), n);
      @(negedge clk);
      check("t2_full_ready", {in_ready, fifo_count}, {1'b0, 3'd4});
      push(8'h05, n);
      wait_idle(500);

      // timeout, sticky error, clear, then set-wins against clear
      ack_mode = 0;
      push(8'h5A, n);
      wait_idle(200);
      @(negedge clk); check("t3_err_sticky", timeout_err, 1'b1);
      clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
      check("t3_err_clr", timeout_err, 1'b0);
      ack_mode = 1;
      push(8'h66, n);
      wait_idle(200);
      check("t3_next_ok", timeout_err, 1'b0);
      ack_mode = 0; clr_err = 1'b1;
      push(8'h77, n);
      wait_idle(200);
      clr_err = 1'b0;
      @(negedge clk); check("t3_set_wins", timeout_err, 1'b1);
      clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;

      // ack while CA1 is still active
      ack_mode = 1; ack_d = 0;
      push(8'h3C, n);
      wait_idle(200);
      check("t4_no_tmo", timeout_err, 1'b0);

      // enable gating and drop of enable mid-wait
      enable = 1'b0; ack_d = 10;
      push(8'h11, n); push(8'h22, n);
      s = strobes;
      repeat (20) @(negedge clk);
      check("t5_hold", {busy, fifo_count, 8'(strobes - s)}, {1'b0, 3'd2, 8'd0});
      enable = 1'b1;
      wait_ca1_active();
      repeat (STROBE + 1) @(negedge clk);
      check("t5_in_wait", {busy, ca1_out}, 2'b11);
      enable = 1'b0;
      n = 0;
      while (busy && n < 100) begin @(negedge clk); n++; end
      repeat (30) @(negedge clk);
      check("t5_after", {busy, fifo_count, 8'(strobes - s)}, {1'b0, 3'd1, 8'd1});
      enable = 1'b1;
      wait_idle(200);

      // reset during STROBE with three bytes queued
      ack_mode = 0; ack_d = -1;
      push(8'h44, n);
      wait_idle(200);
      push(8'h91, n); push(8'h92, n); push(8'h93, n);
      wait_ca1_active();
      @(negedge clk);
      check("t6_pre_count", fifo_count, 3);
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst", {ca1_out, pa_data, fifo_count, timeout_err, busy}, {1'b1, 8'hFF, 3'd0, 1'b0, 1'b0});
      exp_q.delete(); out_q.delete(); pushes = 0; completions = 0;
      @(negedge clk); reset = 1'b0;
      ack_mode = 1;
      push(8'hC3, n);
      wait_idle(200);
      check("t6_after", {fifo_count, timeout_err}, {3'd0, 1'b0});

      // random traffic
      ack_mode = 2;
      for (int i = 0; i < 40; i++) begin
         g = int'($urandom_range(0, 3));
         repeat (g + 1) @(negedge clk);
         enable = (fifo_count < 3'(DEPTH)) ? ($urandom_range(0, 3) != 0) : 1'b1;
         push(8'($urandom), n);
      end
      enable = 1'b1;
      wait_idle(3000);
      check("rand_leftover", exp_q.size() + out_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
